// File: rtl/ctrl_pkg.sv
// Shared types for the ID-stage decode and hazard controller: opcodes, ALU/writeback encodings
// and the control bundle carried into EX.
package ctrl_pkg;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSub  = 4'b0001,
    AluSlt  = 4'b0010,
    AluSltu = 4'b0011,
    AluXor  = 4'b0100,
    AluOr   = 4'b0101,
    AluAnd  = 4'b0110,
    AluSll  = 4'b0111,
    AluSrl  = 4'b1000,
    AluSra  = 4'b1001,
    AluLui  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    WbAlu  = 2'b00,
    WbLoad = 2'b01,
    WbPc4  = 2'b10
  } wb_sel_e;

  typedef struct packed {
    logic        insn_vld;
    logic        rd_wren;
    logic        mem_wren;
    logic        op_a_sel;
    logic        op_b_sel;
    wb_sel_e     wb_sel;
    alu_op_e     alu_op;
    logic [2:0]  l_length;
    logic        l_unsigned;
    logic [1:0]  s_length;
    logic [2:0]  br_type;
    logic        is_branch;
    logic        jump;
    logic [4:0]  rd;
  } ctrl_bundle_t;

  localparam int unsigned CTRL_W = $bits(ctrl_bundle_t);

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? AluSub : AluAdd;
      3'b001:  return AluSll;
      3'b010:  return AluSlt;
      3'b011:  return AluSltu;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      default: return AluAnd;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I/RV32E decoder: instruction to control bundle, source usage and illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned RF_AW = 5
) (
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         rs1_used,
  output logic         rs2_used,
  output logic         illegal
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [4:0]   rd, rs1, rs2;
  logic         bad_op;
  ctrl_bundle_t dec;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  function automatic logic reg_oob(input logic [4:0] r);
    return (32'(r) >> RF_AW) != 32'd0;
  endfunction

  always_comb begin
    dec          = '0;
    dec.insn_vld = 1'b1;
    rs1_used     = 1'b0;
    rs2_used     = 1'b0;
    bad_op       = 1'b0;
    case (opcode)
      OpcLui: begin
        dec.rd_wren  = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.alu_op   = AluLui;
      end
      OpcAuipc: begin
        dec.rd_wren  = 1'b1;
        dec.op_a_sel = 1'b1;
        dec.op_b_sel = 1'b1;
      end
      OpcJal: begin
        dec.rd_wren  = 1'b1;
        dec.op_a_sel = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.wb_sel   = WbPc4;
        dec.jump     = 1'b1;
      end
      OpcJalr: begin
        dec.rd_wren  = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.wb_sel   = WbPc4;
        dec.jump     = 1'b1;
        rs1_used     = 1'b1;
      end
      OpcBranch: begin
        dec.is_branch = 1'b1;
        dec.br_type   = funct3;
        dec.op_a_sel  = 1'b1;
        dec.op_b_sel  = 1'b1;
        rs1_used      = 1'b1;
        rs2_used      = 1'b1;
        bad_op        = (funct3[2:1] == 2'b01);
      end
      OpcLoad: begin
        dec.rd_wren    = 1'b1;
        dec.op_b_sel   = 1'b1;
        dec.wb_sel     = WbLoad;
        dec.l_length   = funct3;
        dec.l_unsigned = funct3[2] & ~funct3[1];
        rs1_used       = 1'b1;
      end
      OpcStore: begin
        dec.mem_wren = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.s_length = funct3[1:0];
        rs1_used     = 1'b1;
        rs2_used     = 1'b1;
      end
      OpcOpImm: begin
        dec.rd_wren  = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.alu_op   = alu_from_f3(funct3, (funct3 == 3'b101) && instr[30]);
        rs1_used     = 1'b1;
      end
      OpcOp: begin
        dec.rd_wren = 1'b1;
        dec.alu_op  = alu_from_f3(funct3, funct7[5]);
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
        bad_op      = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      default: bad_op = 1'b1;
    endcase
    if (dec.rd_wren) dec.rd = rd;

    illegal = bad_op | (rs1_used & reg_oob(rs1)) | (rs2_used & reg_oob(rs2)) |
              (dec.rd_wren & reg_oob(rd));
    ctrl    = illegal ? '0 : dec;
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID/EX control register with RAW scoreboard stall, EX-branch flush and saturating event counters.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned HAZ_DEPTH = 3,
  parameter int unsigned RF_AW     = 5,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_instr,
  input  logic              i_instr_vld,
  input  logic              i_br_taken,
  output logic              o_stall,
  output logic              o_flush,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic              o_illegal,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  ctrl_bundle_t         dec_ctrl, ex_ctrl_q;
  logic                 rs1_used, rs2_used, illegal;
  logic [4:0]           rs1, rs2;
  logic                 raw, hazard, issue, illegal_q;
  logic [HAZ_DEPTH-1:0] sb_vld_q;
  logic [4:0]           sb_rd_q [HAZ_DEPTH];
  logic [CNT_W-1:0]     stall_cnt_q, flush_cnt_q;

  ctrl_decode #(
    .RF_AW(RF_AW)
  ) u_decode (
    .instr    (i_instr),
    .ctrl     (dec_ctrl),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .illegal  (illegal)
  );

  assign rs1 = i_instr[19:15];
  assign rs2 = i_instr[24:20];

  always_comb begin
    raw = 1'b0;
    for (int unsigned i = 0; i < HAZ_DEPTH; i++) begin
      if (sb_vld_q[i] && rs1_used && (rs1 != 5'd0) && (sb_rd_q[i] == rs1)) raw = 1'b1;
      if (sb_vld_q[i] && rs2_used && (rs2 != 5'd0) && (sb_rd_q[i] == rs2)) raw = 1'b1;
    end
  end

  assign hazard  = i_instr_vld && !illegal && raw;
  assign o_flush = i_br_taken;
  assign o_stall = hazard && !i_br_taken;
  assign issue   = i_instr_vld && !i_br_taken && !hazard;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ex_ctrl_q   <= '0;
      illegal_q   <= 1'b0;
      sb_vld_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      for (int unsigned i = 0; i < HAZ_DEPTH; i++) sb_rd_q[i] <= '0;
    end else begin
      ex_ctrl_q   <= issue ? dec_ctrl : '0;
      illegal_q   <= issue && illegal;
      // Illegal instructions decode with rd_wren=0, so they never enter the scoreboard.
      sb_vld_q[0] <= issue && dec_ctrl.rd_wren && (dec_ctrl.rd != 5'd0);
      sb_rd_q[0]  <= dec_ctrl.rd;
      for (int unsigned i = 1; i < HAZ_DEPTH; i++) begin
        sb_vld_q[i] <= sb_vld_q[i-1];
        sb_rd_q[i]  <= sb_rd_q[i-1];
      end
      if (o_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (o_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign o_ex_ctrl   = ex_ctrl_q;
  assign o_illegal   = illegal_q;
  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed bench: a default instance and an RV32E/HAZ_DEPTH=2/2-bit-counter instance on shared inputs.
module tb_ctrl_pipe_unit;
  import ctrl_pkg::*;

  localparam logic [31:0] AddiX1   = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] AddX2    = 32'h00108133;  // add x2,x1,x1
  localparam logic [31:0] AddiX0   = 32'h00100013;  // addi x0,x0,1
  localparam logic [31:0] AddX3    = 32'h000001B3;  // add x3,x0,x0
  localparam logic [31:0] AddX5X31 = 32'h01FF82B3;  // add x5,x31,x31
  localparam logic [31:0] AddX17   = 32'h002088B3;  // add x17,x1,x2

  logic         clk = 1'b0;
  logic         rst, vld, br;
  logic [31:0]  instr;
  logic         stall_a, flush_a, ill_a, stall_b, flush_b, ill_b;
  ctrl_bundle_t ex_a, ex_b;
  logic [31:0]  scnt_a, fcnt_a;
  logic [1:0]   scnt_b, fcnt_b;
  int           n_total = 0;
  int           n_bad = 0;
  int           na, nb;

  always #5 clk = ~clk;

  ctrl_pipe_unit u_dut_a (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_instr     (instr),
    .i_instr_vld (vld),
    .i_br_taken  (br),
    .o_stall     (stall_a),
    .o_flush     (flush_a),
    .o_ex_ctrl   (ex_a),
    .o_illegal   (ill_a),
    .o_stall_cnt (scnt_a),
    .o_flush_cnt (fcnt_a)
  );

  ctrl_pipe_unit #(
    .HAZ_DEPTH (2),
    .RF_AW     (4),
    .CNT_W     (2)
  ) u_dut_b (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_instr     (instr),
    .i_instr_vld (vld),
    .i_br_taken  (br),
    .o_stall     (stall_b),
    .o_flush     (flush_b),
    .o_ex_ctrl   (ex_b),
    .o_illegal   (ill_b),
    .o_stall_cnt (scnt_b),
    .o_flush_cnt (fcnt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic ctrl_bundle_t alu_bundle(input logic [4:0] rd, input logic imm);
    ctrl_bundle_t b;
    b          = '0;
    b.insn_vld = 1'b1;
    b.rd_wren  = 1'b1;
    b.op_b_sel = imm;
    b.rd       = rd;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    br  = 1'b0;
    repeat (n) tick();
  endtask

  // addi x1 then a dependent add x2 held in ID until instance A stops stalling.
  task automatic run_dep(output int sa, output int sb);
    vld   = 1'b1;
    br    = 1'b0;
    instr = AddiX1;
    #1 check_eq("dep_addi_stall", 32'(stall_a), 32'd0);
    tick();
    check_eq("dep_addi_ex", 32'(ex_a), 32'(alu_bundle(5'd1, 1'b1)));
    instr = AddX2;
    sa = 0;
    sb = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 1) check_eq("dep_stall_bubble", 32'(ex_a), 32'd0);
      if (stall_a) sa++;
      if (stall_b) sb++;
      if (!stall_a) break;
      tick();
    end
    tick();
    check_eq("dep_add_ex", 32'(ex_a), 32'(alu_bundle(5'd2, 1'b0)));
    vld = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    vld   = 1'b0;
    br    = 1'b0;
    instr = '0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_ex_a", 32'(ex_a), 32'd0);
    check_eq("rst_ill_a", 32'(ill_a), 32'd0);
    check_eq("rst_scnt_a", scnt_a, 32'd0);
    check_eq("rst_fcnt_a", fcnt_a, 32'd0);
    check_eq("rst_ex_b", 32'(ex_b), 32'd0);

    // Dependency on the immediately preceding instruction.
    run_dep(na, nb);
    check_eq("dep_stall_len_a", 32'(na), 32'd3);
    check_eq("dep_stall_len_b", 32'(nb), 32'd2);
    check_eq("dep_scnt_a", scnt_a, 32'd3);
    check_eq("dep_scnt_b", 32'(scnt_b), 32'd2);
    idle(4);

    // Writes to and reads of x0 never stall.
    vld   = 1'b1;
    instr = AddiX0;
    #1 check_eq("x0_addi_stall", 32'(stall_a), 32'd0);
    tick();
    check_eq("x0_addi_ex", 32'(ex_a), 32'(alu_bundle(5'd0, 1'b1)));
    instr = AddX3;
    #1 check_eq("x0_add_stall", 32'(stall_a), 32'd0);
    tick();
    check_eq("x0_add_ex", 32'(ex_a), 32'(alu_bundle(5'd3, 1'b0)));
    idle(1);

    // Flush wins over a pending hazard.
    vld   = 1'b1;
    instr = AddiX1;
    tick();
    instr = AddX2;
    br    = 1'b1;
    #1 check_eq("flush_stall_a", 32'(stall_a), 32'd0);
    check_eq("flush_flush_a", 32'(flush_a), 32'd1);
    check_eq("flush_stall_b", 32'(stall_b), 32'd0);
    tick();
    check_eq("flush_ex_a", 32'(ex_a), 32'd0);
    check_eq("flush_fcnt_a", fcnt_a, 32'd1);
    check_eq("flush_fcnt_b", 32'(fcnt_b), 32'd1);
    idle(4);
    check_eq("flush_scnt_a", scnt_a, 32'd3);

    // Illegal opcode: bubble, one-cycle pulse, no scoreboard entry.
    vld   = 1'b1;
    instr = 32'hFFFF_FFFF;
    #1 check_eq("ill_stall_a", 32'(stall_a), 32'd0);
    tick();
    check_eq("ill_ex_a", 32'(ex_a), 32'd0);
    check_eq("ill_pulse_a", 32'(ill_a), 32'd1);
    instr = AddX5X31;
    #1 check_eq("ill_next_stall_a", 32'(stall_a), 32'd0);
    tick();
    check_eq("ill_pulse_end_a", 32'(ill_a), 32'd0);
    check_eq("ill_next_ex_a", 32'(ex_a), 32'(alu_bundle(5'd5, 1'b0)));
    check_eq("ill_x31_b", 32'(ill_b), 32'd1);
    idle(4);

    // rd=17 is illegal only in RV32E.
    vld   = 1'b1;
    instr = AddX17;
    #1 check_eq("e_stall_b", 32'(stall_b), 32'd0);
    tick();
    check_eq("e_ill_b", 32'(ill_b), 32'd1);
    check_eq("e_ex_b", 32'(ex_b), 32'd0);
    check_eq("e_ill_a", 32'(ill_a), 32'd0);
    check_eq("e_ex_a", 32'(ex_a), 32'(alu_bundle(5'd17, 1'b0)));
    idle(4);

    // Second dependency run drives instance B's 2-bit stall counter past all-ones.
    run_dep(na, nb);
    check_eq("sat_scnt_a", scnt_a, 32'd6);
    check_eq("sat_scnt_b", 32'(scnt_b), 32'd3);
    idle(4);

    // Reset during the second stall cycle.
    vld   = 1'b1;
    instr = AddiX1;
    tick();
    instr = AddX2;
    #1 check_eq("rst_mid_stall1", 32'(stall_a), 32'd1);
    tick();
    check_eq("rst_mid_stall2", 32'(stall_a), 32'd1);
    check_eq("rst_mid_scnt", scnt_a, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst2_ex_a", 32'(ex_a), 32'd0);
    check_eq("rst2_ill_a", 32'(ill_a), 32'd0);
    check_eq("rst2_scnt_a", scnt_a, 32'd0);
    check_eq("rst2_fcnt_a", fcnt_a, 32'd0);
    check_eq("rst2_scnt_b", 32'(scnt_b), 32'd0);
    #1 check_eq("rst2_stall_a", 32'(stall_a), 32'd0);
    tick();
    check_eq("rst2_add_ex", 32'(ex_a), 32'(alu_bundle(5'd2, 1'b0)));
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
Name: ctrl_pipe_unit

Overview:
Registered decode and hazard controller for the pipelined RV32I core without forwarding. It decodes the ID-stage instruction into a control bundle and registers that bundle into ID/EX. A parametrised destination-register scoreboard detects RAW hazards and raises a stall until the producer retires. A branch or jump resolved in EX flushes ID. Stall and flush events are counted for performance reporting, and RV32E mode (16 registers) is supported.

Parameters:
HAZ_DEPTH, 3, in-flight stages tracked after ID (EX, MEM, WB). Use 2 when the regfile is write-through.
RF_AW, 5, register address bits actually implemented. 4 selects RV32E; any rs1/rs2/rd field of 16 or above is then illegal.
CNT_W, 32, width of the performance counters. Counters saturate.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_instr  in  32  IF/ID instruction
i_instr_vld  in  1  IF/ID slot holds a real instruction (0 = bubble)
i_br_taken  in  1  EX resolved a taken branch, JAL or JALR this cycle
o_stall  out  1  hold PC and IF/ID (combinational)
o_flush  out  1  kill IF/ID contents (combinational; equals i_br_taken)
o_ex_ctrl  out  CTRL_W  registered ctrl_bundle_t for EX
o_illegal  out  1  registered one-cycle pulse: an illegal instruction entered EX
o_stall_cnt  out  CNT_W  cycles with o_stall=1
o_flush_cnt  out  CNT_W  cycles with o_flush=1

Behaviour:
- Reset (i_rst=1 at a clk edge): o_ex_ctrl is all-zero (a bubble, insn_vld=0). o_illegal=0. Both counters are 0. All scoreboard entries are invalid. Reset has priority over every other event, including mid-stall and mid-flush.
- Decode (combinational, sub-module):
  - ALU encoding: ADD=0000, SUB=0001, SLT=0010, SLTU=0011, XOR=0100, OR=0101, AND=0110, SLL=0111, SRL=1000, SRA=1001, LUI=1010.
  - wb_sel: 00 = ALU, 01 = load, 10 = PC+4. op_a_sel 1 = PC. op_b_sel 1 = immediate.
  - l_length = funct3 and l_unsigned = funct3 in {100,101}. s_length = funct3[1:0].
  - Branch condition is not decoded in ID. br_type holds funct3 for B-type, and jump=1 for JAL/JALR.
- Source usage:
  - rs1 and rs2 are used by R, S and B.
  - rs1 only is used by I-IMM, LD and JALR.
  - No source is used by LUI, AUIPC and JAL.
- Illegal instruction: unknown opcode, R-type funct7 not in {0000000, 0100000}, B-type funct3 in {010, 011}, or a register field at or above 2^RF_AW.
  - An illegal instruction gets a bundle with insn_vld=0, rd_wren=0 and mem_wren=0.
  - It never stalls and makes no scoreboard entry.
  - o_illegal pulses in the cycle the instruction sits in EX.
- Scoreboard: HAZ_DEPTH entries {vld, rd[4:0]}, shifting every cycle. Entry 0 is loaded with the instruction issued from ID this cycle. It is valid only if issued, rd_wren=1 and rd≠0.
- hazard: i_instr_vld, the instruction is legal, and a used rs≠0 equals the rd of any valid entry.
- Priority, evaluated per cycle:
  1. i_br_taken: o_flush=1, o_stall=0. ID/EX loads a bubble, entry 0 is invalid, and o_flush_cnt increments.
  2. hazard: o_stall=1. ID/EX loads a bubble, entry 0 is invalid, and o_stall_cnt increments.
  3. Otherwise ID issues: ID/EX loads the decoded bundle, with a bubble if i_instr_vld=0.
- Latency: ID to o_ex_ctrl is 1 cycle. With back-to-back dependent instructions, the stall lasts exactly HAZ_DEPTH cycles for a dependency on the immediately preceding instruction, and HAZ_DEPTH−k cycles for a producer k slots earlier.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Package ctrl_pkg contains:
  - opcode constants
  - alu_op_e enum
  - wb_sel_e enum
  - ctrl_bundle_t, a packed struct: insn_vld, rd_wren, mem_wren, op_a_sel, op_b_sel, wb_sel[1:0], alu_op[3:0], l_length[2:0], l_unsigned, s_length[1:0], br_type[2:0], is_branch, jump, rd[4:0]
  - localparam CTRL_W = $bits(ctrl_bundle_t)
- Sub-module ctrl_decode is purely combinational. It maps an instruction and RF_AW to ctrl_bundle_t, rs1_used, rs2_used and illegal. The scoreboard, priority logic and counters stay in the top level.

Test Plan:
- addi x1,x0,5 (0x00500093) then add x2,x1,x1 (0x00108133), HAZ_DEPTH=3 → o_stall high for 3 cycles. The add appears in o_ex_ctrl on cycle 5 with alu_op=0000, rd=2. o_stall_cnt=3.
- addi x0,x0,1 (0x00100013) then add x3,x0,x0 → no stall. o_ex_ctrl.rd=3 one cycle after the add enters ID.
- Dependent add in ID with i_br_taken=1 in the same cycle → o_stall=0, o_flush=1. The next o_ex_ctrl is all-zero. o_flush_cnt=1, o_stall_cnt unchanged.
- i_instr=0xFFFFFFFF → o_ex_ctrl.insn_vld=0, o_illegal=1 for one cycle, no stall. A following use of any register does not stall on it.
- RF_AW=4, add x17,x1,x2 (0x002088B3) → treated as illegal and o_illegal pulses. With RF_AW=5 it decodes normally with rd=17.
- i_rst asserted during the second stall cycle → next cycle: all outputs 0 and scoreboard cleared. The same add then issues without a stall.
